// File: rtl/div_arbiter.sv
// Round-robin front end that shares one start-by-reset divider among NREQ requesters.
// Optional build macro DIV_ZERO_CHK_EN: zero divisors are answered locally without touching the divider.
module div_arbiter #(
  parameter int NREQ    = 4,
  parameter int PW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   dvdend_in,
  input  logic [32*NREQ-1:0]   dvsor_in,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [31:0]          quotient_out,
  output logic [63:0]          remainder_out,
  output logic                 busy,
  output logic                 div_start,
  output logic [31:0]          div_dvdend,
  output logic [31:0]          div_dvsor,
  input  logic                 div_finished,
  input  logic [31:0]          div_quotient,
  input  logic [63:0]          div_remainder
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   gnt_reg;
  logic [CW-1:0]   cnt_reg;
  logic            fin_q;
`ifdef DIV_ZERO_CHK_EN
  logic            zero_reg;
`endif

  logic [31:0]     dvdend_arr [NREQ];
  logic [31:0]     dvsor_arr  [NREQ];
  logic [NREQ-1:0] gnt_onehot;
  logic            found;
  logic            hi_found;
  logic [PW-1:0]   hi_sel;
  logic [PW-1:0]   wrap_sel;
  logic [PW-1:0]   gsel;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign dvdend_arr[gi] = dvdend_in[32*gi +: 32];
      assign dvsor_arr[gi]  = dvsor_in[32*gi +: 32];
    end
  endgenerate

  assign gnt_onehot = NREQ'(1) << gnt_reg;

  // Prefer the lowest request above the pointer; otherwise wrap to the lowest request overall.
  always_comb begin
    found    = 1'b0;
    hi_found = 1'b0;
    hi_sel   = '0;
    wrap_sel = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found    = 1'b1;
        wrap_sel = PW'(i);
        if (PW'(i) > ptr_reg) begin
          hi_found = 1'b1;
          hi_sel   = PW'(i);
        end
      end
    end
    gsel = hi_found ? hi_sel : wrap_sel;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= PW'(NREQ - 1);
      gnt_reg       <= '0;
      cnt_reg       <= '0;
      fin_q         <= 1'b1;
      done          <= '0;
      err           <= 1'b0;
      busy          <= 1'b0;
      quotient_out  <= '0;
      remainder_out <= '0;
      div_dvdend    <= '0;
      div_dvsor     <= '0;
      div_start     <= 1'b1;
`ifdef DIV_ZERO_CHK_EN
      zero_reg      <= 1'b0;
`endif
    end else begin
      fin_q <= div_finished;
      case (state_reg)
        IDLE: begin
          div_start <= 1'b0;
          if (found) begin
            ptr_reg    <= gsel;
            gnt_reg    <= gsel;
            div_dvdend <= dvdend_arr[gsel];
            div_dvsor  <= dvsor_arr[gsel];
            busy       <= 1'b1;
            state_reg  <= START;
`ifdef DIV_ZERO_CHK_EN
            zero_reg   <= (dvsor_arr[gsel] == 32'd0);
            div_start  <= (dvsor_arr[gsel] != 32'd0);
`else
            div_start  <= 1'b1;
`endif
          end
        end
        START: begin
          div_start <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= WAIT;
`ifdef DIV_ZERO_CHK_EN
          if (zero_reg) begin
            quotient_out  <= 32'hFFFF_FFFF;
            remainder_out <= {32'h0, div_dvdend};
            err           <= 1'b1;
            done          <= gnt_onehot;
            busy          <= 1'b0;
            state_reg     <= DONE;
          end
`endif
        end
        WAIT: begin
          // Only a fresh low-to-high transition counts; a level left over from before is ignored.
          if (div_finished && !fin_q) begin
            quotient_out  <= div_quotient;
            remainder_out <= div_remainder;
            err           <= 1'b0;
            done          <= gnt_onehot;
            busy          <= 1'b0;
            state_reg     <= DONE;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            quotient_out  <= 32'hFFFF_FFFF;
            remainder_out <= '0;
            err           <= 1'b1;
            done          <= gnt_onehot;
            busy          <= 1'b0;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          done      <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed-plus-random bench for div_arbiter with a behavioural start-by-reset divider stub
// and a round-robin reference model built from plain arithmetic.
module tb_div_arbiter;
  localparam int NREQ = 4;
  localparam int PW   = 3;
  localparam int TMO  = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [32*NREQ-1:0]  dvdend_in;
  logic [32*NREQ-1:0]  dvsor_in;
  logic [NREQ-1:0]     done;
  logic                err;
  logic [31:0]         quotient_out;
  logic [63:0]         remainder_out;
  logic                busy;
  logic                div_start;
  logic [31:0]         div_dvdend;
  logic [31:0]         div_dvsor;
  logic                div_finished = 1'b0;
  logic [31:0]         div_quotient = '0;
  logic [63:0]         div_remainder = '0;

  always #5 clk = ~clk;

  div_arbiter #(.NREQ(NREQ), .PW(PW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .dvdend_in(dvdend_in), .dvsor_in(dvsor_in),
    .done(done), .err(err), .quotient_out(quotient_out), .remainder_out(remainder_out),
    .busy(busy), .div_start(div_start), .div_dvdend(div_dvdend), .div_dvsor(div_dvsor),
    .div_finished(div_finished), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  // Divider stub: held in reset by div_start, finishes lat cycles after release unless hung.
  bit hang = 1'b0;
  int lat  = 4;
  int dcnt = 0;
  always @(posedge clk) begin
    if (div_start) begin
      dcnt         <= lat;
      div_finished <= 1'b0;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && !hang) begin
        div_finished  <= 1'b1;
        div_quotient  <= (div_dvsor == 0) ? 32'hFFFF_FFFF : div_dvdend / div_dvsor;
        div_remainder <= (div_dvsor == 0) ? {32'h0, div_dvdend} : {32'h0, div_dvdend % div_dvsor};
      end
    end
  end

  // Counts rising edges of div_start (one per divider launch).
  int   start_cnt = 0;
  logic ds_q = 1'b0;
  always @(posedge clk) begin
    ds_q <= div_start;
    if (div_start && !ds_q) start_cnt <= start_cnt + 1;
  end

  int passed = 0;
  int total  = 0;
  int snap   = 0;
  int mptr   = NREQ - 1;
  logic [31:0]     opa [NREQ];
  logic [31:0]     opb [NREQ];
  logic [NREQ-1:0] pend;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    dvdend_in[32*i +: 32] = a;
    dvsor_in[32*i +: 32]  = b;
    opa[i] = a;
    opb[i] = b;
  endtask

  // Reference arbitration: first pending requester after the last winner, modulo NREQ.
  function automatic int rr_pick(input int p, input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic wait_done(input string tag);
    int n = 0;
    while (done == '0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_arrived"}, 64'(done != '0), 64'd1);
  endtask

  task automatic serve(input int exp_idx, input bit chk_start);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[exp_idx] = 1'b1;
    wait_done("serve");
    $display("txn: done=%b q=%0d r=%0d err=%0b (expect requester %0d, %0d/%0d)",
             done, quotient_out, remainder_out, err, exp_idx, opa[exp_idx], opb[exp_idx]);
    check("serve_owner", 64'(done), 64'(oh));
    check("serve_quot", 64'(quotient_out), 64'(opa[exp_idx] / opb[exp_idx]));
    check("serve_rem", remainder_out, {32'h0, opa[exp_idx] % opb[exp_idx]});
    check("serve_err", 64'(err), 64'd0);
    check("serve_busy", 64'(busy), 64'd0);
    if (chk_start) check("serve_one_launch", 64'(start_cnt - snap), 64'd1);
    snap = start_cnt;
    mptr = exp_idx;
    tick();
    check("serve_pulse_once", 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int e;
    reset = 1'b0; req = '0; dvdend_in = '0; dvsor_in = '0; pend = '0;
    for (int i = 0; i < NREQ; i++) begin opa[i] = 32'd1; opb[i] = 32'd1; end

    // Reset values while held, then release.
    repeat (3) tick();
    check("rst_div_start", 64'(div_start), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_quot", 64'(quotient_out), 64'd0);
    check("rst_rem", remainder_out, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_dvdend", 64'(div_dvdend), 64'd0);
    reset = 1'b1;
    tick();
    check("rel_div_start", 64'(div_start), 64'd0);
    check("rel_busy", 64'(busy), 64'd0);
    check("rel_done", 64'(done), 64'd0);

    // Single request 7/2 from requester 1.
    snap = start_cnt;
    set_op(1, 32'd7, 32'd2);
    req = 4'b0010;
    lat = 5;
    tick();
    check("grant_busy", 64'(busy), 64'd1);
    check("grant_start", 64'(div_start), 64'd1);
    check("grant_dvdend", 64'(div_dvdend), 64'd7);
    dvdend_in[32*1 +: 32] = 32'd99;
    tick();
    check("start_one_cycle", 64'(div_start), 64'd0);
    serve(1, 1'b1);
    check("operand_stable", 64'(div_dvdend), 64'd7);
    req = '0;
    set_op(1, 32'd7, 32'd2);

    // Fresh reset, then all four held: expected order 0,1,2,3,0.
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    mptr = NREQ - 1;
    tick();
    snap = start_cnt;
    set_op(0, 32'd100, 32'd7);
    set_op(1, 32'd50, 32'd5);
    set_op(2, 32'd9, 32'd4);
    set_op(3, 32'd81, 32'd9);
    pend = 4'b1111;
    req = pend;
    for (int t = 0; t < 5; t++) begin
      lat = $urandom_range(1, 12);
      e = rr_pick(mptr, pend);
      check("rr_fixed_order", 64'(e), 64'(t % NREQ));
      serve(e, 1'b1);
    end

    // Randomized traffic: served requester drops, others join with random operands.
    for (int t = 0; t < 20; t++) begin
      pend[mptr] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          set_op(i, $urandom, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 100) : ($urandom | 32'd1));
          pend[i] = 1'b1;
        end
      end
      if (pend == '0) begin
        n = $urandom_range(0, NREQ - 1);
        set_op(n, $urandom, $urandom_range(1, 1000));
        pend[n] = 1'b1;
      end
      req = pend;
      lat = $urandom_range(1, 12);
      serve(rr_pick(mptr, pend), 1'b1);
    end
    pend = '0;
    req = '0;
    tick(); tick();

    // Divider that never finishes: timeout result.
    hang = 1'b1;
    set_op(3, 32'd20, 32'd3);
    req = 4'b1000;
    n = 0;
    while (!div_start && n < 20) begin tick(); n++; end
    check("tmo_launch", 64'(div_start), 64'd1);
    n = 0;
    while (done == '0 && n < 100) begin tick(); n++; end
    $display("txn: timeout done=%b after %0d cycles q=%0h r=%0h err=%0b", done, n, quotient_out, remainder_out, err);
    check("tmo_latency_16_18", 64'(n >= 16 && n <= 18), 64'd1);
    check("tmo_owner", 64'(done), 64'b1000);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_quot", 64'(quotient_out), 64'hFFFF_FFFF);
    check("tmo_rem", remainder_out, 64'd0);
    req = '0;
    tick();
    hang = 1'b0;
    mptr = 3;
    tick();

    // Reset while waiting on the divider; requester 2 pending at release.
    lat = 12;
    set_op(0, 32'd40, 32'd6);
    req = 4'b0001;
    n = 0;
    while (!div_start && n < 20) begin tick(); n++; end
    repeat (4) tick();
    check("midop_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    req = 4'b0100;
    set_op(2, 32'd77, 32'd8);
    lat = 3;
    tick();
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_start", 64'(div_start), 64'd1);
    tick();
    check("midrst_done2", 64'(done), 64'd0);
    reset = 1'b1;
    mptr = NREQ - 1;
    serve(rr_pick(mptr, 4'b0100), 1'b0);
    req = '0;
    tick(); tick();

    // Zero divisor.
    snap = start_cnt;
    set_op(0, 32'd5, 32'd0);
    req = 4'b0001;
    lat = 4;
`ifdef DIV_ZERO_CHK_EN
    tick();
    check("zdiv_grant_nodone", 64'(done), 64'd0);
    check("zdiv_no_start", 64'(div_start), 64'd0);
    tick();
    $display("txn: zero divisor done=%b q=%0h r=%0h err=%0b", done, quotient_out, remainder_out, err);
    check("zdiv_done", 64'(done), 64'b0001);
    check("zdiv_err", 64'(err), 64'd1);
    check("zdiv_quot", 64'(quotient_out), 64'hFFFF_FFFF);
    check("zdiv_rem", remainder_out, 64'd5);
    check("zdiv_never_launched", 64'(start_cnt - snap), 64'd0);
`else
    wait_done("zdiv");
    $display("txn: zero divisor passed through, done=%b err=%0b", done, err);
    check("zdiv_launched", 64'(start_cnt - snap), 64'd1);
    check("zdiv_done", 64'(done), 64'b0001);
    check("zdiv_err", 64'(err), 64'd0);
`endif
    req = '0;
    tick();
    check("zdiv_pulse_once", 64'(done), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
